// File: rtl/ram_banked_clr.sv
// Banked single-port RAM with a registered read path and a zero-fill sweep that runs after reset and on request.
// Optional even-parity storage and checking is enabled by defining PARITY_EN.
module ram_banked_clr #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14,
  parameter int NUM_BANKS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  parity_err
);

  localparam int BANK_BITS  = $clog2(NUM_BANKS);
  localparam int IDX_BITS   = ADDR_WIDTH - BANK_BITS;
  localparam int BANK_DEPTH = 1 << IDX_BITS;
  // Zero-width fields are widened to one bit and tied off below.
  localparam int IW = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int BW = (BANK_BITS > 0) ? BANK_BITS : 1;

`ifdef PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   cnt_reg, cnt_next;
  logic            sweep;
  logic            acc_wr;
  logic            acc_rd;
  logic [IW-1:0]   idx;
  logic [BW-1:0]   bsel;
  logic [MW-1:0]   wr_word;
  logic [MW-1:0]   bank_rd [NUM_BANKS];
  logic [MW-1:0]   rd_word;
  logic [BW-1:0]   rd_sel_reg;
  logic            out_valid_reg;

  generate
    if (IDX_BITS > 0) begin : g_idx
      assign idx = address[IW-1:0];
    end else begin : g_idx0
      assign idx = '0;
    end
    if (BANK_BITS > 0) begin : g_bsel
      assign bsel = address[ADDR_WIDTH-1 -: BW];
    end else begin : g_bsel0
      assign bsel = '0;
    end
  endgenerate

`ifdef PARITY_EN
  assign wr_word = {^in, in};
`else
  assign wr_word = in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sweep      = 1'b0;
    acc_wr     = 1'b0;
    acc_rd     = 1'b0;
    case (state_reg)
      S_CLEAR: begin
        sweep    = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == IW'(BANK_DEPTH - 1)) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      end
      S_IDLE: begin
        // clear wins over a same-cycle access, which is dropped
        if (clear) begin
          state_next = S_CLEAR;
        end else if (en) begin
          acc_wr = rw;
          acc_rd = ~rw;
        end
      end
      default: begin
        state_next = S_CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  // During the sweep every bank writes zero at the same index in parallel.
  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      localparam logic [BW-1:0] BANK_ID = BW'(gi);
      logic [MW-1:0] mem [BANK_DEPTH];
      logic [MW-1:0] rd_reg;
      logic          we;
      logic          re;
      logic [IW-1:0] waddr;
      logic [MW-1:0] wdata;

      assign we    = sweep | (acc_wr && (bsel == BANK_ID));
      assign re    = acc_rd && (bsel == BANK_ID);
      assign waddr = sweep ? cnt_reg : idx;
      assign wdata = sweep ? '0 : wr_word;

      always_ff @(posedge clk) begin
        if (we) begin
          mem[waddr] <= wdata;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_reg <= '0;
        end else if (re) begin
          rd_reg <= mem[idx];
        end
      end

      assign bank_rd[gi] = rd_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sel_reg    <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= acc_rd;
      if (acc_rd) begin
        rd_sel_reg <= bsel;
      end
    end
  end

  // Bank read registers only load on a read, so out holds between reads.
  assign rd_word   = bank_rd[rd_sel_reg];
  assign out       = rd_word[DATA_WIDTH-1:0];
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg == S_CLEAR);

`ifdef PARITY_EN
  assign parity_err = out_valid_reg & (^rd_word);
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_banked_clr.sv
// Directed bench for ram_banked_clr: sweep length, banked read/write, clear, reset mid-sweep, small configs.
module tb_ram_banked_clr;

  logic        clk;
  logic        rst;
  logic        en, rw, clear;
  logic [13:0] address;
  logic [15:0] din;
  logic [15:0] out;
  logic        out_valid, busy, parity_err;

  logic        en_s, rw_s, clear_s;
  logic [3:0]  addr_s;
  logic [7:0]  din_s;
  logic [7:0]  out_s;
  logic        ov_s, busy_s, pe_s;

  logic        en_t, rw_t, clear_t;
  logic [3:0]  addr_t;
  logic [7:0]  din_t;
  logic [7:0]  out_t;
  logic        ov_t, busy_t, pe_t;

  int          total;
  int          bad;
  logic        want;
  logic        want_perr;
  logic [15:0] rq [$];

  ram_banked_clr dut (
    .clk(clk), .rst(rst), .en(en), .rw(rw), .address(address), .in(din), .clear(clear),
    .out(out), .out_valid(out_valid), .busy(busy), .parity_err(parity_err)
  );

  ram_banked_clr #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_BANKS(1)) dut_s (
    .clk(clk), .rst(rst), .en(en_s), .rw(rw_s), .address(addr_s), .in(din_s), .clear(clear_s),
    .out(out_s), .out_valid(ov_s), .busy(busy_s), .parity_err(pe_s)
  );

  ram_banked_clr #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_BANKS(16)) dut_t (
    .clk(clk), .rst(rst), .en(en_t), .rw(rw_t), .address(addr_t), .in(din_t), .clear(clear_t),
    .out(out_t), .out_valid(ov_t), .busy(busy_t), .parity_err(pe_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: DUT samples on posedge, outputs checked on the following negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check("out_valid", {31'd0, out_valid}, {31'd0, want});
    if (want) begin
      check("rdata", {16'd0, out}, {16'd0, rq.pop_front()});
      check("parity_err", {31'd0, parity_err}, {31'd0, want_perr});
    end else begin
      check("parity_idle", {31'd0, parity_err}, 32'd0);
    end
    en = 1'b0; rw = 1'b0; clear = 1'b0; want = 1'b0; want_perr = 1'b0;
  endtask

  task automatic wr(input logic [13:0] a, input logic [15:0] d);
    en = 1'b1; rw = 1'b1; address = a; din = d;
    tick();
  endtask

  task automatic rd(input logic [13:0] a, input logic [15:0] e, input logic pe);
    en = 1'b1; rw = 1'b0; address = a;
    rq.push_back(e);
    want = 1'b1; want_perr = pe;
    tick();
  endtask

  // Counts busy cycles from the current negedge; optional noise drives accesses and clears that must be ignored.
  task automatic sweep(input string tag, input int exp_n, input bit noise);
    int n;
    n = 0;
    while (busy === 1'b1 && n < exp_n + 50) begin
      if (noise) begin
        en = 1'b1; rw = n[0]; address = 14'h0010; din = 16'h7777;
        clear = ((n % 100) == 5);
      end
      n++;
      tick();
    end
    check(tag, n, exp_n);
  endtask

  initial begin
    int nm, ns, nt;
    total = 0; bad = 0;
    want = 1'b0; want_perr = 1'b0;
    en = 0; rw = 0; clear = 0; address = '0; din = '0;
    en_s = 0; rw_s = 0; clear_s = 0; addr_s = '0; din_s = '0;
    en_t = 0; rw_t = 0; clear_t = 0; addr_t = '0; din_t = '0;

    // 1: reset state and sweep lengths for all three configurations
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out", {16'd0, out}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    nm = 0; ns = 0; nt = 0;
    for (int c = 0; c < 4200; c++) begin
      if (busy) nm++;
      if (busy_s) ns++;
      if (busy_t) nt++;
      if (!busy && !busy_s && !busy_t) break;
      tick();
    end
    check("sweep_main", nm, 4096);
    check("sweep_nb1", ns, 16);
    check("sweep_nb16", nt, 1);
    rd(14'h3FFF, 16'h0000, 1'b0);
    rd(14'h0000, 16'h0000, 1'b0);

    // 2: one write per bank, reverse reads back to back
    wr(14'h0000, 16'hBEEF);
    wr(14'h1000, 16'h1234);
    wr(14'h2000, 16'h5A5A);
    wr(14'h3FFF, 16'hA5A5);
    rd(14'h3FFF, 16'hA5A5, 1'b0);
    rd(14'h2000, 16'h5A5A, 1'b0);
    rd(14'h1000, 16'h1234, 1'b0);
    rd(14'h0000, 16'hBEEF, 1'b0);
    tick();
    check("hold_out", {16'd0, out}, 32'h0000BEEF);
    wr(14'h0040, 16'h0123);
    check("write_keeps_out", {16'd0, out}, 32'h0000BEEF);
    rd(14'h0040, 16'h0123, 1'b0);
    rd(14'h0001, 16'h0000, 1'b0);
    rd(14'h2FFF, 16'h0000, 1'b0);

    // 3: clear beats a same-cycle write; accesses during sweep are ignored
    clear = 1'b1; en = 1'b1; rw = 1'b1; address = 14'h0010; din = 16'hFFFF;
    tick();
    sweep("sweep_clear", 4096, 1'b1);
    rd(14'h0000, 16'h0000, 1'b0);
    rd(14'h0010, 16'h0000, 1'b0);
    rd(14'h0040, 16'h0000, 1'b0);

    // 4: reset at sweep index 2000 restarts the full sweep
    wr(14'h3FFF, 16'hBEEF);
    rd(14'h3FFF, 16'hBEEF, 1'b0);
    clear = 1'b1;
    tick();
    repeat (2000) tick();
    rst = 1'b1;
    #1;
    check("midrst_out", {16'd0, out}, 32'd0);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sweep("sweep_after_rst", 4096, 1'b0);
    rd(14'h3FFF, 16'h0000, 1'b0);

    // 5: single-bank small config write/read
    en_s = 1'b1; rw_s = 1'b1; addr_s = 4'hF; din_s = 8'hC3;
    tick();
    en_s = 1'b1; rw_s = 1'b0;
    tick();
    check("nb1_valid", {31'd0, ov_s}, 32'd1);
    check("nb1_data", {24'd0, out_s}, 32'h000000C3);
    en_s = 1'b0;
    tick();
    check("nb1_strobe", {31'd0, ov_s}, 32'd0);

`ifdef PARITY_EN
    // 6: corrupt a stored data bit and expect a parity error on read
    wr(14'h0005, 16'h0001);
    dut.g_bank[0].mem[5] = dut.g_bank[0].mem[5] ^ 17'h00001;
    rd(14'h0005, 16'h0000, 1'b1);
    rd(14'h0006, 16'h0000, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
